sd_kin_sequencer: RTL and testbench

Tone sequencer that drives the frequency word `kin` and the modulator reset of the two-piece sigma-delta modulator. Accepts (target word, dwell length) requests over a valid/ready handshake, slews `kin` linearly to each target to avoid spectral splatter, holds it for the dwell period, then either chains the next request or ramps to zero and parks the modulator in reset. Sits between the test/host stimulus logic and the modulator instance.

---
 rtl/sd_kin_sequencer.sv | 126 ++++++++++++
 tb/tb_sd_kin_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_kin_sequencer.sv
// Frequency-word sequencer for the sigma-delta modulator: slews kin to each requested
// target, dwells, then chains or ramps to zero and parks the modulator. Option: SD_SEQ_MUTE_EN.
module sd_kin_sequencer #(
    parameter int          BITWIDTH = 32,
    parameter int          DWELLW   = 16,
    parameter int unsigned STEP     = 1024
) (
    input  logic                clk,
    input  logic                reset,
`ifdef SD_SEQ_MUTE_EN
    input  logic                mute,
`endif
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [BITWIDTH-1:0] req_kin,
    input  logic [DWELLW-1:0]   req_dwell,
    output logic [BITWIDTH-1:0] kin,
    output logic                sd_reset,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RAMP   = 2'd1;
    localparam logic [1:0] S_DWELL  = 2'd2;
    localparam logic [1:0] S_RAMPDN = 2'd3;

    localparam logic [BITWIDTH:0] STEP_W = (BITWIDTH+1)'(STEP);

    logic [1:0]          state;
    logic [DWELLW-1:0]   cnt;
    logic [BITWIDTH-1:0] target;

    logic                mute_i;
    logic                last_dwell;
    logic                accept;
    logic [DWELLW-1:0]   dwell_eff;
    logic [BITWIDTH-1:0] slew_tgt;
    logic [BITWIDTH-1:0] kin_step;
    logic [BITWIDTH:0]   diff;
    logic                up;
    logic                arrive;

`ifdef SD_SEQ_MUTE_EN
    assign mute_i = mute & ((state == S_RAMP) | (state == S_DWELL));
`else
    assign mute_i = 1'b0;
`endif

    assign last_dwell = (state == S_DWELL) && (cnt == DWELLW'(1));
    assign req_ready  = (state == S_IDLE) || (last_dwell && !mute_i);
    assign accept     = req_valid && req_ready;
    assign busy       = (state != S_IDLE);
    assign done       = last_dwell && !mute_i;
    assign dwell_eff  = (req_dwell == '0) ? DWELLW'(1) : req_dwell;

    // Distance is taken one bit wider so a full-scale target can never wrap the compare.
    assign slew_tgt = (state == S_RAMPDN) ? '0 : target;
    assign up       = (slew_tgt >= kin);
    assign diff     = up ? ({1'b0, slew_tgt} - {1'b0, kin})
                         : ({1'b0, kin} - {1'b0, slew_tgt});
    assign arrive   = (diff <= STEP_W);
    assign kin_step = up ? (kin + STEP_W[BITWIDTH-1:0]) : (kin - STEP_W[BITWIDTH-1:0]);

    // NOTE: every register here uses <= so all of them sample the pre-edge values together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            kin      <= '0;
            sd_reset <= 1'b1;
            cnt      <= '0;
            target   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        target   <= req_kin;
                        cnt      <= dwell_eff;
                        sd_reset <= 1'b0;
                        state    <= S_RAMP;
                    end
                end
                S_RAMP: begin
                    if (mute_i) begin
                        target <= '0;
                        state  <= S_RAMPDN;
                    end else if (arrive) begin
                        kin   <= target;
                        state <= S_DWELL;
                    end else begin
                        kin <= kin_step;
                    end
                end
                S_DWELL: begin
                    if (mute_i) begin
                        target <= '0;
                        cnt    <= '0;
                        state  <= S_RAMPDN;
                    end else if (cnt != DWELLW'(1)) begin
                        cnt <= cnt - DWELLW'(1);
                    end else if (accept) begin
                        // Chained tone ramps straight from the current word, never via zero.
                        target <= req_kin;
                        cnt    <= dwell_eff;
                        state  <= S_RAMP;
                    end else begin
                        target <= '0;
                        cnt    <= '0;
                        state  <= S_RAMPDN;
                    end
                end
                S_RAMPDN: begin
                    if (arrive) begin
                        kin      <= '0;
                        sd_reset <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        kin <= kin_step;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_kin_sequencer.sv
// Directed, table-driven bench for sd_kin_sequencer (STEP=1024 instance plus a
// large-STEP instance for the full-scale target), with reset and mute sequences.
module tb_sd_kin_sequencer;

    localparam int BW = 32;
    localparam int DW = 16;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          mute  = 1'b0;
    logic [BW-1:0] req_kin   = '0;
    logic [DW-1:0] req_dwell = '0;

    logic          req_valid = 1'b0;
    logic          req_ready, sd_reset, busy, done;
    logic [BW-1:0] kin;

    logic          b_valid = 1'b0;
    logic          b_ready, b_sd_reset, b_busy, b_done;
    logic [BW-1:0] b_kin;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_kin_sequencer #(.BITWIDTH(BW), .DWELLW(DW), .STEP(1024)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef SD_SEQ_MUTE_EN
        .mute      (mute),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kin   (req_kin),
        .req_dwell (req_dwell),
        .kin       (kin),
        .sd_reset  (sd_reset),
        .busy      (busy),
        .done      (done)
    );

    sd_kin_sequencer #(.BITWIDTH(BW), .DWELLW(DW), .STEP(32'h6000_0000)) dut_big (
        .clk       (clk),
        .reset     (reset),
`ifdef SD_SEQ_MUTE_EN
        .mute      (1'b0),
`endif
        .req_valid (b_valid),
        .req_ready (b_ready),
        .req_kin   (req_kin),
        .req_dwell (req_dwell),
        .kin       (b_kin),
        .sd_reset  (b_sd_reset),
        .busy      (b_busy),
        .done      (b_done)
    );

    typedef struct {
        bit            big;
        bit            valid;
        bit            mute;
        logic [BW-1:0] rk;
        logic [DW-1:0] rd;
        bit            e_ready;
        logic [BW-1:0] e_kin;
        bit            e_sdr;
        bit            e_busy;
        bit            e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit big, input bit valid, input bit m,
                       input int unsigned rk, input int unsigned rd,
                       input bit er, input int unsigned ek,
                       input bit es, input bit eb, input bit ed);
        vec_t v;
        v.big = big; v.valid = valid; v.mute = m;
        v.rk = rk; v.rd = DW'(rd);
        v.e_ready = er; v.e_kin = ek; v.e_sdr = es; v.e_busy = eb; v.e_done = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        bit found;

        // Single tone 4096 / dwell 3
        add(0,1,0, 4096,3, 1,   0,1,0,0);
        add(0,0,0,    0,0, 0,   0,0,1,0);
        add(0,0,0,    0,0, 0,1024,0,1,0);
        add(0,0,0,    0,0, 0,2048,0,1,0);
        add(0,0,0,    0,0, 0,3072,0,1,0);
        add(0,0,0,    0,0, 0,4096,0,1,0);
        add(0,0,0,    0,0, 0,4096,0,1,0);
        add(0,0,0,    0,0, 1,4096,0,1,1);
        add(0,0,0,    0,0, 0,4096,0,1,0);
        add(0,0,0,    0,0, 0,3072,0,1,0);
        add(0,0,0,    0,0, 0,2048,0,1,0);
        add(0,0,0,    0,0, 0,1024,0,1,0);
        add(0,0,0,    0,0, 1,   0,1,0,0);
        // Non-multiple target 2500 / dwell 1
        add(0,1,0, 2500,1, 1,   0,1,0,0);
        add(0,0,0,    0,0, 0,   0,0,1,0);
        add(0,0,0,    0,0, 0,1024,0,1,0);
        add(0,0,0,    0,0, 0,2048,0,1,0);
        add(0,0,0,    0,0, 1,2500,0,1,1);
        add(0,0,0,    0,0, 0,2500,0,1,0);
        add(0,0,0,    0,0, 0,1476,0,1,0);
        add(0,0,0,    0,0, 0, 452,0,1,0);
        add(0,0,0,    0,0, 1,   0,1,0,0);
        // Chaining: 4096/2, then 1024/2 held valid from the RAMP phase
        add(0,1,0, 4096,2, 1,   0,1,0,0);
        add(0,1,0, 1024,2, 0,   0,0,1,0);
        add(0,1,0, 1024,2, 0,1024,0,1,0);
        add(0,1,0, 1024,2, 0,2048,0,1,0);
        add(0,1,0, 1024,2, 0,3072,0,1,0);
        add(0,1,0, 1024,2, 0,4096,0,1,0);
        add(0,1,0, 1024,2, 1,4096,0,1,1);
        add(0,0,0,    0,0, 0,4096,0,1,0);
        add(0,0,0,    0,0, 0,3072,0,1,0);
        add(0,0,0,    0,0, 0,2048,0,1,0);
        add(0,0,0,    0,0, 0,1024,0,1,0);
        add(0,0,0,    0,0, 1,1024,0,1,1);
        add(0,0,0,    0,0, 0,1024,0,1,0);
        add(0,0,0,    0,0, 1,   0,1,0,0);
        // Full-scale target with dwell 0 on the large-step instance
        add(1,1,0, 32'hFFFF_FFFF,0, 1,0,1,0,0);
        add(1,0,0, 0,0, 0,32'h0000_0000,0,1,0);
        add(1,0,0, 0,0, 0,32'h6000_0000,0,1,0);
        add(1,0,0, 0,0, 0,32'hC000_0000,0,1,0);
        add(1,0,0, 0,0, 1,32'hFFFF_FFFF,0,1,1);
        add(1,0,0, 0,0, 0,32'hFFFF_FFFF,0,1,0);
        add(1,0,0, 0,0, 0,32'h9FFF_FFFF,0,1,0);
        add(1,0,0, 0,0, 0,32'h3FFF_FFFF,0,1,0);
        add(1,0,0, 0,0, 1,32'h0000_0000,1,0,0);
`ifdef SD_SEQ_MUTE_EN
        // Mute on the last dwell cycle: no done, no accept, straight to ramp-down
        add(0,1,0, 4096,2, 1,   0,1,0,0);
        add(0,0,0,    0,0, 0,   0,0,1,0);
        add(0,0,0,    0,0, 0,1024,0,1,0);
        add(0,0,0,    0,0, 0,2048,0,1,0);
        add(0,0,0,    0,0, 0,3072,0,1,0);
        add(0,0,0,    0,0, 0,4096,0,1,0);
        add(0,1,1, 1024,1, 0,4096,0,1,0);
        add(0,0,0,    0,0, 0,4096,0,1,0);
        add(0,0,0,    0,0, 0,3072,0,1,0);
        add(0,0,0,    0,0, 0,2048,0,1,0);
        add(0,0,0,    0,0, 0,1024,0,1,0);
        add(0,0,0,    0,0, 1,   0,1,0,0);
`endif

        #1 reset = 1'b1;
        #2;
        check("rst kin",       64'(kin),        64'd0);
        check("rst sd_reset",  64'(sd_reset),   64'd1);
        check("rst busy",      64'(busy),       64'd0);
        check("rst done",      64'(done),       64'd0);
        check("rst req_ready", 64'(req_ready),  64'd1);
        check("rst big kin",   64'(b_kin),      64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            logic          a_ready, a_sdr, a_busy, a_done;
            logic [BW-1:0] a_kin;
            @(negedge clk);
            req_valid = !vecs[i].big && vecs[i].valid;
            b_valid   =  vecs[i].big && vecs[i].valid;
            mute      =  vecs[i].mute;
            req_kin   =  vecs[i].rk;
            req_dwell =  vecs[i].rd;
            #1;
            a_ready = vecs[i].big ? b_ready    : req_ready;
            a_kin   = vecs[i].big ? b_kin      : kin;
            a_sdr   = vecs[i].big ? b_sd_reset : sd_reset;
            a_busy  = vecs[i].big ? b_busy     : busy;
            a_done  = vecs[i].big ? b_done     : done;
            check($sformatf("v%0d req_ready", i), 64'(a_ready), 64'(vecs[i].e_ready));
            check($sformatf("v%0d kin", i),       64'(a_kin),   64'(vecs[i].e_kin));
            check($sformatf("v%0d sd_reset", i),  64'(a_sdr),   64'(vecs[i].e_sdr));
            check($sformatf("v%0d busy", i),      64'(a_busy),  64'(vecs[i].e_busy));
            check($sformatf("v%0d done", i),      64'(a_done),  64'(vecs[i].e_done));
        end

        // Asynchronous reset in the middle of a dwell at kin=4096
        @(negedge clk);
        req_valid = 1'b1; b_valid = 1'b0; mute = 1'b0;
        req_kin = 4096; req_dwell = 8;
        @(negedge clk);
        req_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            #1;
            if (busy && kin == 4096) found = 1'b1;
        end
        check("reach dwell", 64'(found), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst kin",       64'(kin),       64'd0);
        check("midrst sd_reset",  64'(sd_reset),  64'd1);
        check("midrst busy",      64'(busy),      64'd0);
        check("midrst req_ready", 64'(req_ready), 64'd1);
        check("midrst done",      64'(done),      64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
